// File: rtl/stopwatch_display_mux.sv
// Six-digit multiplexed 7-segment driver for hh.mm.ss. Converts a once-per-frame
// snapshot of binary time fields to BCD and scans common-anode digits.
module stopwatch_display_mux #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       hold,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_TC = CW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [CW-1:0] div_cnt;
    logic [2:0]    digit_idx;
    logic          primed;
    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [4:0]    snap_hr;

    logic          tc;
    logic          wrap;
    logic [5:0]    field_val;
    logic          field_bad;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_units;
    logic [3:0]    digit_val;
    logic [6:0]    seg_nxt;
    logic [5:0]    an_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign tc   = (div_cnt == DIV_TC);
    assign wrap = tc && (digit_idx == 3'd5);

    always_comb begin
        field_val = 6'd0;
        field_bad = 1'b0;
        case (digit_idx)
            3'd0, 3'd1: begin
                field_val = snap_sec;
                field_bad = (snap_sec > 6'd59);
            end
            3'd2, 3'd3: begin
                field_val = snap_min;
                field_bad = (snap_min > 6'd59);
            end
            3'd4, 3'd5: begin
                field_val = {1'b0, snap_hr};
                field_bad = (snap_hr > 5'd23);
            end
            default: begin
                field_val = 6'd0;
                field_bad = 1'b0;
            end
        endcase
        bcd_tens  = 4'(field_val / 6'd10);
        bcd_units = 4'(field_val % 6'd10);
        digit_val = digit_idx[0] ? bcd_tens : bcd_units;
        seg_nxt   = field_bad ? SEG_DASH : seg_decode(digit_val);
        an_nxt    = ~(6'b000001 << digit_idx);
        dp_nxt    = !((digit_idx == 3'd2) || (digit_idx == 3'd4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            digit_idx  <= 3'd0;
            primed     <= 1'b0;
            snap_sec   <= 6'd0;
            snap_min   <= 6'd0;
            snap_hr    <= 5'd0;
            an         <= 6'b111111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (tc) begin
                div_cnt   <= '0;
                digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // Snapshot only at the frame boundary so a rollover never tears a frame.
            if (!primed || (wrap && !hold)) begin
                snap_sec <= seconds;
                snap_min <= minutes;
                snap_hr  <= hours;
            end
            primed     <= 1'b1;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Directed bench for stopwatch_display_mux with SCAN_DIV=4 (24-cycle frames).
module tb_stopwatch_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] seconds = 6'd0;
    logic [5:0] minutes = 6'd0;
    logic [4:0] hours   = 5'd0;
    logic       hold    = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};
    localparam logic [6:0] DASH = 7'b0111111;

    stopwatch_display_mux #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .seconds(seconds), .minutes(minutes), .hours(hours),
        .hold(hold), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n cycles and check the display while digit k is enabled.
    task automatic check_digit(input int n, input int k, input logic [6:0] exp, input string tag);
        logic [5:0] an_exp;
        step(n);
        an_exp    = 6'b111111;
        an_exp[k] = 1'b0;
        chk($sformatf("%s_an%0d", tag, k), 7'(an), 7'(an_exp));
        chk($sformatf("%s_seg%0d", tag, k), seg, exp);
        chk($sformatf("%s_dp%0d", tag, k), 7'(dp), 7'((k == 2 || k == 4) ? 1'b0 : 1'b1));
    endtask

    // Starts one cycle before digit 0 appears; ends on the last cycle of digit 5.
    task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                               input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                               input string tag);
        check_digit(4, 0, s0, tag);
        check_digit(4, 1, s1, tag);
        check_digit(4, 2, s2, tag);
        check_digit(4, 3, s3, tag);
        check_digit(4, 4, s4, tag);
        check_digit(4, 5, s5, tag);
        chk({tag, "_frame_done"}, 7'(frame_done), 7'd1);
    endtask

    initial begin
        int  since;
        int  nfd;
        logic prev_fd;

        // reset values
        seconds = 6'd37; minutes = 6'd5; hours = 5'd12; hold = 1'b0;
        rst = 1'b1;
        step(2);
        chk("rst_an", 7'(an), 7'b0111111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_dp", 7'(dp), 7'd1);
        chk("rst_fd", 7'(frame_done), 7'd0);
        rst = 1'b0;

        // 12:05:37
        check_frame(SEG[7], SEG[3], SEG[5], SEG[0], SEG[2], SEG[1], "f1");

        // inputs change between captures: frame 2 keeps 37/05
        seconds = 6'd59; minutes = 6'd4;
        check_frame(SEG[7], SEG[3], SEG[5], SEG[0], SEG[2], SEG[1], "f2");

        // 59/04, then rollover to 00/05 while digit 2 is active
        check_digit(4, 0, SEG[9], "f3");
        check_digit(4, 1, SEG[5], "f3");
        check_digit(2, 2, SEG[4], "f3mid");
        seconds = 6'd0; minutes = 6'd5;
        check_digit(2, 2, SEG[4], "f3");
        check_digit(4, 3, SEG[0], "f3");
        check_digit(4, 4, SEG[2], "f3");
        check_digit(4, 5, SEG[1], "f3");
        check_frame(SEG[0], SEG[0], SEG[5], SEG[0], SEG[2], SEG[1], "f4");

        // hold across two boundaries while inputs advance
        hold = 1'b1; seconds = 6'd10; minutes = 6'd20;
        check_frame(SEG[0], SEG[0], SEG[5], SEG[0], SEG[2], SEG[1], "hold1");
        seconds = 6'd11;
        check_frame(SEG[0], SEG[0], SEG[5], SEG[0], SEG[2], SEG[1], "hold2");
        hold = 1'b0;
        check_frame(SEG[0], SEG[0], SEG[5], SEG[0], SEG[2], SEG[1], "hold3");
        check_frame(SEG[1], SEG[1], SEG[0], SEG[2], SEG[2], SEG[1], "release");

        // out-of-range fields blank to dashes
        seconds = 6'd60; minutes = 6'd33; hours = 5'd24;
        check_frame(SEG[1], SEG[1], SEG[0], SEG[2], SEG[2], SEG[1], "pre_range");
        check_frame(DASH, DASH, SEG[3], SEG[3], DASH, DASH, "range");

        // reset pulse while digit 3 is enabled
        step(13);
        chk("pre_rst_an", 7'(an), 7'b0110111);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_an", 7'(an), 7'b0111111);
        chk("mid_rst_seg", seg, 7'b1111111);
        chk("mid_rst_dp", 7'(dp), 7'd1);
        chk("mid_rst_fd", 7'(frame_done), 7'd0);
        step(1);
        chk("post_rst_an", 7'(an), 7'b0111110);
        chk("post_rst_seg", seg, SEG[0]);
        check_digit(3, 0, DASH, "rst_frame");
        check_digit(4, 1, DASH, "rst_frame");
        check_digit(4, 2, SEG[3], "rst_frame");
        check_digit(4, 3, SEG[3], "rst_frame");
        check_digit(4, 4, DASH, "rst_frame");
        check_digit(4, 5, DASH, "rst_frame");
        chk("rst_frame_fd", 7'(frame_done), 7'd1);

        // every cycle for three frames: one-hot-low an, periodic single-cycle frame_done
        since   = 0;
        nfd     = 0;
        prev_fd = 1'b1;
        for (int i = 0; i < 72; i++) begin
            step(1);
            since++;
            chk("an_onehot", 7'($countones(~an)), 7'd1);
            if (prev_fd) begin
                chk("fd_width", 7'(frame_done), 7'd0);
                chk("fd_next_an", 7'(an), 7'b0111110);
            end
            if (frame_done) begin
                nfd++;
                chk("fd_period", 7'(since), 7'd24);
                chk("fd_an", 7'(an), 7'b0011111);
                since = 0;
            end
            prev_fd = frame_done;
        end
        chk("fd_count", 7'(nfd), 7'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
